// File: rtl/fetch_defs.sv
// Shared definitions for the instruction fetch unit: state encoding and sizing.
package fetch_defs;

    localparam int WIDTH         = 16;
    localparam int TCNT_W        = 4;
    localparam int FETCH_TIMEOUT = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_HOLD  = 2'b10,
        S_DRAIN = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Up-counting wait timer; done flags the cycle on which the count would reach LIMIT.
module fetch_timer
    import fetch_defs::*;
#(
    parameter int TCNT_W = fetch_defs::TCNT_W,
    parameter int LIMIT  = fetch_defs::FETCH_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [TCNT_W-1:0] count_q;
    logic [TCNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the LIMIT-th consecutive ack-less cycle, so the abort lands on that edge.
    assign done = enable && (count_q == TCNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: issues one memory read at a time, holds the
// returned word for decode, and handles flush, drain and timeout abort.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | no request outstanding, nothing held
//   S_WAIT  | request outstanding, response will be captured
//   S_HOLD  | instruction held for decode (instrValid=1)
//   S_DRAIN | request outstanding but flushed; response will be dropped
module fetch_unit
    import fetch_defs::*;
#(
    parameter int FETCH_TIMEOUT = fetch_defs::FETCH_TIMEOUT,
    parameter int WIDTH         = fetch_defs::WIDTH,
    parameter int TCNT_W        = fetch_defs::TCNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pcIn,
    input  logic             fetchEn,
    input  logic             flush,
    input  logic             memAck,
    input  logic [WIDTH-1:0] memData,
    input  logic             instrTaken,
    output logic             memReq,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instrPc,
    output logic             instrValid,
    output logic             pcAdvance,
    output logic             fetchErr
);

    fetch_state_e     state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_err_q, fetch_err_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_done;

    fetch_timer #(
        .TCNT_W (TCNT_W),
        .LIMIT  (FETCH_TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .done   (tmr_done)
    );

    assign tmr_enable = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !memAck;

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        tmr_clear     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fetchEn && !flush) begin
                    state_d    = S_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pcIn;
                    tmr_clear  = 1'b1;
                end
            end
            S_WAIT: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d       = S_HOLD;
                        instr_d       = memData;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                    end
                end else if (tmr_done) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (memAck) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end else if (tmr_done) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                end else if (instrTaken) begin
                    instr_valid_d = 1'b0;
                    if (fetchEn) begin
                        state_d    = S_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pcIn;
                        tmr_clear  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // PC moves on the same edge that captures the word, never for dropped data.
    assign pcAdvance  = (state_q == S_WAIT) && memAck && !flush;

    assign memReq     = mem_req_q;
    assign memAddr    = mem_addr_q;
    assign instr      = instr_q;
    assign instrPc    = instr_pc_q;
    assign instrValid = instr_valid_q;
    assign fetchErr   = fetch_err_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15, max WAIT/DRAIN cycles without memAck before abort.
REQ-002 Parameters WIDTH=16 (data/address width) and TCNT_W=4 (timeout counter width), both fixed.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pcIn  input  16  current PC from pc_block (pcOut).
REQ-006 fetchEn  input  1  control requests instruction fetch.
REQ-007 flush  input  1  taken branch/jump; discard pending or held instruction.
REQ-008 memAck  input  1  instruction memory has returned data this cycle.
REQ-009 memData  input  16  instruction word, valid when memAck=1.
REQ-010 instrTaken  input  1  decode consumes held instruction this cycle.
REQ-011 memReq  output  1  read request, registered.
REQ-012 memAddr  output  16  read address, registered, stable while memReq=1.
REQ-013 instr  output  16  captured instruction word.
REQ-014 instrPc  output  16  address from which instr was fetched.
REQ-015 instrValid  output  1  instr/instrPc valid for decode.
REQ-016 pcAdvance  output  1  combinational; drives pc_block pcWrite for PC+1.
REQ-017 fetchErr  output  1  sticky timeout error flag.

Function
REQ-018 FSM states IDLE, WAIT, HOLD, DRAIN; exactly one active.
REQ-019 IDLE: fetchEn=1 and flush=0 -> WAIT; memReq<=1, memAddr<=pcIn, counter<=0; otherwise stay IDLE.
REQ-020 WAIT: memReq=1, memAddr unchanged; counter increments each cycle without memAck.
REQ-021 WAIT, memAck=1, flush=0: instr<=memData, instrPc<=memAddr, instrValid<=1, memReq<=0 -> HOLD.
REQ-022 pcAdvance = (state==WAIT) & memAck & ~flush, so PC updates on the capture edge; asserted in no other case.
REQ-023 WAIT, flush=1, memAck=1: data dropped, memReq<=0 -> IDLE, no pcAdvance.
REQ-024 WAIT, flush=1, memAck=0 -> DRAIN; memReq stays 1 until ack.
REQ-025 DRAIN: on memAck, data dropped, memReq<=0 -> IDLE; flush ignored in DRAIN.
REQ-026 HOLD: instrValid=1, instr/instrPc stable until consumed or flushed.
REQ-027 HOLD, flush=1: instrValid<=0 -> IDLE; flush has priority over instrTaken.
REQ-028 HOLD, instrTaken=1, fetchEn=1: instrValid<=0, memReq<=1, memAddr<=pcIn, counter<=0 -> WAIT (back-to-back).
REQ-029 HOLD, instrTaken=1, fetchEn=0: instrValid<=0 -> IDLE.
REQ-030 Timeout: counter reaching FETCH_TIMEOUT in WAIT or DRAIN without memAck sets fetchErr<=1, memReq<=0 -> IDLE, no capture.
REQ-031 fetchErr cleared only by reset; fetching continues normally after error.
REQ-032 Minimum fetch latency: memReq rise to instrValid rise = memory ack latency + 1 cycle.
REQ-033 memAck in IDLE or HOLD ignored entirely.

Reset
REQ-034 reset=1 at rising edge: state<=IDLE, counter<=0, memReq, memAddr, instr, instrPc, instrValid, fetchErr all <=0.
REQ-035 Reset overrides all inputs, including mid-WAIT/DRAIN; outstanding memory response after reset is ignored.

Structure
REQ-036 State encoding (IDLE=2'b00, WAIT=2'b01, HOLD=2'b10, DRAIN=2'b11) and FETCH_TIMEOUT belong in shared definitions file fetch_defs.
REQ-037 Timeout counter is natural sub-module fetch_timer (clear, enable, done); all else inline.

Verification
REQ-038 Reset, pcIn=0x0010, fetchEn=1, memAck 2 cycles later with 0xA5A5 -> instr=0xA5A5, instrPc=0x0010, instrValid=1, pcAdvance one pulse.
REQ-039 HOLD with instrTaken=1, fetchEn=1, pcIn=0x0011 -> next cycle memReq=1, memAddr=0x0011, instrValid=0.
REQ-040 flush in WAIT, memAck 3 cycles later -> DRAIN then IDLE, instrValid stays 0, pcAdvance never 1.
REQ-041 flush and instrTaken together in HOLD -> IDLE, memReq=0, instrValid=0.
REQ-042 No memAck for 15 cycles after memReq -> fetchErr=1, memReq=0, state IDLE; fetchErr stays 1 until reset.
REQ-043 reset asserted mid-WAIT, memAck arrives next cycle -> all outputs 0, no capture, no pcAdvance.
